uart_rx: RTL and testbench

//  Serial receiver: the downstream counterpart of the UART transmitter; consumes its tx line.

---
 rtl/uart_rx.sv | 130 +++++++++++++
 tb/tb_uart_rx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver (8E1 when UART_RX_PARITY_EN is defined) with a memory-mapped holding register and sticky flags
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       uart_sel,
  input  logic       rd,
  output logic [7:0] data_out,
  output logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY     = 3'd5;
  localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
  localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif
  localparam logic [15:0] TICK = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] MID  = 16'(CLKS_PER_BIT / 2 - 1);

  logic        rx_meta_q, rx_s_q;
  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d, data_q, data_d;
  logic        ready_q, ready_d, ferr_q, ferr_d, ovr_q, ovr_d, perr_q, perr_d;
  logic        tick, load, ferr_set, pbad_set, rd_eff;
`ifdef UART_RX_PARITY_EN
  logic        pbad_q, pbad_d;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    load     = 1'b0;
    ferr_set = 1'b0;
    tick     = cnt_q == TICK;
`ifdef UART_RX_PARITY_EN
    pbad_d   = pbad_q;
`endif
    case (state_q)
      S_IDLE:  state_d = rx_s_q ? S_IDLE : S_START;
      S_START: if (cnt_q == MID) begin
        state_d = rx_s_q ? S_IDLE : S_DATA;
        idx_d   = 3'd0;
      end
      S_DATA: if (tick) begin
        shift_d = {rx_s_q, shift_q[7:1]};
        idx_d   = idx_q + 3'd1;
        state_d = (idx_q == 3'd7) ? S_AFTER_DATA : S_DATA;
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (tick) begin
        pbad_d  = rx_s_q != ^shift_q;
        state_d = S_STOP;
      end
`endif
      S_STOP: if (tick) begin
        load     = rx_s_q;
        ferr_set = ~rx_s_q;
        state_d  = rx_s_q ? S_IDLE : S_BREAK;
      end
      S_BREAK: state_d = rx_s_q ? S_IDLE : S_BREAK;
      default: state_d = S_IDLE;
    endcase
    // counter restarts on every state change and at each data-bit boundary
    cnt_d = (state_q == S_IDLE || state_d != state_q || (state_q == S_DATA && tick)) ? 16'd0 : cnt_q + 16'd1;
`ifdef UART_RX_PARITY_EN
    pbad_set = load & pbad_q;
`else
    pbad_set = 1'b0;
`endif
    rd_eff  = uart_sel & rd & ready_q;
    data_d  = load ? shift_q : data_q;
    ready_d = (ready_q & ~rd_eff) | load;
    ovr_d   = (ovr_q & ~rd_eff) | (load & ready_q & ~rd_eff);
    ferr_d  = (ferr_q & ~rd_eff) | ferr_set;
    perr_d  = (perr_q & ~rd_eff) | pbad_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      perr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      perr_q    <= perr_d;
`ifdef UART_RX_PARITY_EN
      pbad_q    <= pbad_d;
`endif
    end
  end

  assign data_out   = data_q;
  assign rx_ready   = ready_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign parity_err = perr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames against a frame-level model of the receiver's register/flag behaviour
module tb_uart_rx;
  localparam int CPB = 16;
  // rx_ready appears this many rising edges after the stop bit starts: half a bit, two sync flops, one register
  localparam int LAT = CPB / 2 + 3;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, uart_sel = 1'b0, rd = 1'b0;
  logic [7:0] data_out;
  logic rx_ready, frame_err, overrun, parity_err;
  int checks = 0, errors = 0;
  logic [7:0] m_data = 8'h00;
  logic m_ready = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0, m_perr = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .uart_sel(uart_sel), .rd(rd),
    .data_out(data_out), .rx_ready(rx_ready), .frame_err(frame_err),
    .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data_out"}, data_out, m_data);
    chk({tag, ".rx_ready"}, {7'd0, rx_ready}, {7'd0, m_ready});
    chk({tag, ".frame_err"}, {7'd0, frame_err}, {7'd0, m_ferr});
    chk({tag, ".overrun"}, {7'd0, overrun}, {7'd0, m_ovr});
    chk({tag, ".parity_err"}, {7'd0, parity_err}, {7'd0, m_perr});
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put_bit(input logic v);
    rx = v;
    cycles(CPB);
  endtask

  task automatic do_read();
    uart_sel = 1'b1;
    rd = 1'b1;
    cycles(1);
    uart_sel = 1'b0;
    rd = 1'b0;
    if (m_ready) {m_ready, m_ferr, m_ovr, m_perr} = 4'b0000;
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input logic pflip,
                      input logic rd_at_done, input logic chk_lat);
    logic rd_hit, ovr_new;
    put_bit(1'b0);
    for (int i = 0; i < 8; i++) put_bit(b[i]);
    if (PAR) put_bit(^b ^ pflip);
    rx = stop;
    for (int k = 1; k <= CPB; k++) begin
      if (rd_at_done && k == LAT) begin
        uart_sel = 1'b1;
        rd = 1'b1;
      end
      cycles(1);
      uart_sel = 1'b0;
      rd = 1'b0;
      if (chk_lat && k == LAT - 1) chk("latency_before", {7'd0, rx_ready}, 8'd0);
      if (chk_lat && k == LAT) chk("latency_at", {7'd0, rx_ready}, 8'd1);
    end
    rx = 1'b1;
    rd_hit  = rd_at_done && m_ready;
    ovr_new = stop && m_ready && !rd_hit;
    if (rd_hit) {m_ready, m_ferr, m_ovr, m_perr} = 4'b0000;
    if (stop) begin
      m_ready = 1'b1;
      m_data  = b;
      m_perr  = m_perr | (PAR & pflip);
    end else m_ferr = 1'b1;
    m_ovr = m_ovr | ovr_new;
  endtask

  initial begin
    cycles(3);
    check_all("reset");
    rst = 1'b0;
    cycles(5);
    send(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
    check_all("byte_a5");
    do_read();
    check_all("read_a5");
    rx = 1'b0;
    cycles(4);
    rx = 1'b1;
    cycles(3 * CPB);
    check_all("glitch");
    send(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("after_glitch");
    do_read();
    send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    cycles(100);
    rx = 1'b1;
    cycles(CPB);
    check_all("break");
    send(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("after_break");
    do_read();
    check_all("read_after_break");
    send(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    cycles(3);
    send(8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("overrun");
    do_read();
    check_all("read_overrun");
    do_read();
    check_all("read_when_empty");
    send(8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
    cycles(2);
    send(8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
    check_all("read_at_done");
    do_read();
    send(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    check_all("parity_bad");
    do_read();
    send(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("parity_good");
    send(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    put_bit(1'b0);
    put_bit(1'b1);
    put_bit(1'b0);
    put_bit(1'b1);
    rst = 1'b1;
    rx = 1'b1;
    cycles(1);
    m_data = 8'h00;
    {m_ready, m_ferr, m_ovr, m_perr} = 4'b0000;
    check_all("reset_mid_data");
    rst = 1'b0;
    cycles(2 * CPB);
    send(8'h9E, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("after_reset");
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      b = 8'($urandom);
      send(b, $urandom_range(0, 5) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 1'b0);
      check_all("rnd_frame");
      cycles($urandom_range(2, 20));
      if ($urandom_range(0, 2) == 0) begin
        uart_sel = $urandom_range(0, 1) == 1;
        rd = !uart_sel;
        cycles(1);
        uart_sel = 1'b0;
        rd = 1'b0;
        check_all("rnd_stray");
      end
      if ($urandom_range(0, 1) == 1) begin
        do_read();
        check_all("rnd_read");
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
